// File: rtl/request_recorder_ctrl_pkg.sv
// Shared constants and record layout for the request-recorder tag controller.
package request_recorder_ctrl_pkg;

  // Tag pool size equals the recorder RAM depth.
  localparam int unsigned REQ_TAG_NUM = 32;
  localparam int unsigned REQ_TAG_W   = $clog2(REQ_TAG_NUM);
  localparam int unsigned REQ_REC_W   = 16;

  // Fields captured for each outbound non-posted request.
  typedef struct packed {
    logic [2:0] axi_id;
    logic [7:0] axi_len;
    logic [2:0] axi_size;
    logic [1:0] burst;
  } req_record_t;

  // Flatten a record into the RAM data word.
  function automatic logic [REQ_REC_W-1:0] pack_record(input req_record_t rec);
    return rec;
  endfunction

  // Recover the record fields from a RAM data word.
  function automatic req_record_t unpack_record(input logic [REQ_REC_W-1:0] word);
    return req_record_t'(word);
  endfunction

endpackage

// File: rtl/request_recorder_ctrl_tag_free_finder.sv
// Lowest-index clear-bit priority encoder over the tag allocation bitmap.
module tag_free_finder #(
  parameter int unsigned NUM = 32,
  parameter int unsigned W   = $clog2(NUM)
) (
  input  logic [NUM-1:0] bitmap,
  output logic [W-1:0]   tag,
  output logic           any_free
);

  // Scan from the top down so the lowest clear bit is the last one written.
  always_comb begin
    tag      = '0;
    any_free = 1'b0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (!bitmap[i]) begin
        tag      = W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/request_recorder_ctrl.sv
// Tag allocator and lookup sequencer for the request-recorder dual-port RAM.
// Tags are granted to outbound requests, records are stored at the tag address,
// and a tag is only returned to the pool once its final record is consumed.
module request_recorder_ctrl
  import request_recorder_ctrl_pkg::*;
#(
  parameter int unsigned TAG_NUM = REQ_TAG_NUM,
  parameter int unsigned TAG_W   = $clog2(TAG_NUM),
  parameter int unsigned REC_W   = REQ_REC_W
) (
  input  logic             clk,
  input  logic             rst,
  // Allocation side
  input  logic             alloc_valid,
  input  logic [REC_W-1:0] alloc_record,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  // Completion lookup side
  input  logic             cpl_valid,
  input  logic [TAG_W-1:0] cpl_tag,
  input  logic             cpl_last,
  output logic             cpl_ready,
  // Record output stage
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [TAG_W-1:0] rec_tag,
  output logic [REC_W-1:0] rec_data,
  output logic             rec_last,
  // Recorder RAM
  output logic             ram_wr_en,
  output logic [TAG_W-1:0] ram_wr_addr,
  output logic [REC_W-1:0] ram_wr_data,
  output logic [TAG_W-1:0] ram_rd_addr,
  input  logic [REC_W-1:0] ram_rd_data,
  // Status
  output logic [TAG_W:0]   outstanding,
  output logic             full,
  output logic             empty,
  output logic             err_unalloc
);

  localparam logic [TAG_W:0] FullCount = (TAG_W + 1)'(TAG_NUM);
  localparam logic [TAG_W:0] OneCount  = (TAG_W + 1)'(1);

  logic [TAG_NUM-1:0] bitmap_q, bitmap_d;
  logic [TAG_W:0]     outstanding_q, outstanding_d;
  logic               rec_valid_q, rec_valid_d;
  logic [TAG_W-1:0]   rec_tag_q, rec_tag_d;
  logic               rec_last_q, rec_last_d;
  logic               err_q, err_d;
  logic [TAG_W-1:0]   rd_addr_q, rd_addr_d;

  logic [TAG_W-1:0]   free_tag;
  logic               any_free;
  logic               alloc_hs;
  logic               cpl_hs;
  logic               cpl_hit;
  logic               rec_take;
  logic               rel_fire;

  tag_free_finder #(
    .NUM (TAG_NUM),
    .W   (TAG_W)
  ) u_finder (
    .bitmap   (bitmap_q),
    .tag      (free_tag),
    .any_free (any_free)
  );

  // Handshake decode and combinational outputs.
  always_comb begin
    full        = (outstanding_q == FullCount);
    empty       = (outstanding_q == '0);
    outstanding = outstanding_q;

    // any_free mirrors !full; kept so a counter/bitmap disagreement never grants a used tag.
    alloc_ready = !full && any_free;
    alloc_tag   = free_tag;
    alloc_hs    = alloc_valid && alloc_ready;

    ram_wr_en   = alloc_hs;
    ram_wr_addr = free_tag;
    ram_wr_data = alloc_record;

    cpl_ready   = !rec_valid_q || rec_ready;
    cpl_hs      = cpl_valid && cpl_ready;
    cpl_hit     = bitmap_q[cpl_tag];

    // Hold the read address while stalled so the RAM output stays put.
    ram_rd_addr = cpl_hs ? cpl_tag : rd_addr_q;

    rec_valid   = rec_valid_q;
    rec_tag     = rec_tag_q;
    rec_last    = rec_last_q;
    rec_data    = ram_rd_data;
    err_unalloc = err_q;

    rec_take    = rec_valid_q && rec_ready;
    rel_fire    = rec_take && rec_last_q;
  end

  // Next-state for the output stage, error pulse and held read address.
  always_comb begin
    rec_valid_d = rec_valid_q;
    rec_tag_d   = rec_tag_q;
    rec_last_d  = rec_last_q;
    err_d       = 1'b0;
    rd_addr_d   = rd_addr_q;

    if (cpl_hs) begin
      rd_addr_d   = cpl_tag;
      rec_valid_d = cpl_hit;
      err_d       = !cpl_hit;
      if (cpl_hit) begin
        rec_tag_d  = cpl_tag;
        rec_last_d = cpl_last;
      end
    end else if (rec_take) begin
      rec_valid_d = 1'b0;
    end
  end

  // Next-state for the allocation bitmap and outstanding counter.
  always_comb begin
    bitmap_d      = bitmap_q;
    outstanding_d = outstanding_q;

    // The grant comes from the pre-release bitmap, so set and clear never hit the same bit.
    if (alloc_hs) begin
      bitmap_d[free_tag] = 1'b1;
    end
    if (rel_fire) begin
      bitmap_d[rec_tag_q] = 1'b0;
    end

    unique case ({alloc_hs, rel_fire})
      2'b10:   outstanding_d = outstanding_q + OneCount;
      2'b01:   outstanding_d = outstanding_q - OneCount;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // State registers with synchronous reset; RAM contents are left alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap_q      <= '0;
      outstanding_q <= '0;
      rec_valid_q   <= 1'b0;
      rec_tag_q     <= '0;
      rec_last_q    <= 1'b0;
      err_q         <= 1'b0;
      rd_addr_q     <= '0;
    end else begin
      bitmap_q      <= bitmap_d;
      outstanding_q <= outstanding_d;
      rec_valid_q   <= rec_valid_d;
      rec_tag_q     <= rec_tag_d;
      rec_last_q    <= rec_last_d;
      err_q         <= err_d;
      rd_addr_q     <= rd_addr_d;
    end
  end

endmodule

// File: tb/tb_request_recorder_ctrl.sv
// Self-checking bench for request_recorder_ctrl with a behavioural RAM.
module tb_request_recorder_ctrl;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [15:0] alloc_record;
  logic        alloc_ready;
  logic [4:0]  alloc_tag;
  logic        cpl_valid;
  logic [4:0]  cpl_tag;
  logic        cpl_last;
  logic        cpl_ready;
  logic        rec_valid;
  logic        rec_ready;
  logic [4:0]  rec_tag;
  logic [15:0] rec_data;
  logic        rec_last;
  logic        ram_wr_en;
  logic [4:0]  ram_wr_addr;
  logic [15:0] ram_wr_data;
  logic [4:0]  ram_rd_addr;
  logic [15:0] ram_rd_data;
  logic [5:0]  outstanding;
  logic        full;
  logic        empty;
  logic        err_unalloc;

  logic [15:0] mem [N];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  request_recorder_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_record (alloc_record),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .cpl_valid    (cpl_valid),
    .cpl_tag      (cpl_tag),
    .cpl_last     (cpl_last),
    .cpl_ready    (cpl_ready),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .rec_tag      (rec_tag),
    .rec_data     (rec_data),
    .rec_last     (rec_last),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_wr_data  (ram_wr_data),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_data  (ram_rd_data),
    .outstanding  (outstanding),
    .full         (full),
    .empty        (empty),
    .err_unalloc  (err_unalloc)
  );

  // Dual-port RAM, synchronous read with one cycle latency.
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic av, input logic [15:0] arec, input logic cv,
                       input logic [4:0] ctag, input logic clast, input logic rr);
    alloc_valid  = av;
    alloc_record = arec;
    cpl_valid    = cv;
    cpl_tag      = ctag;
    cpl_last     = clast;
    rec_ready    = rr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        av;
    logic [15:0] rec;
    logic        exp_ready;
    logic [4:0]  exp_tag;
    logic [5:0]  exp_out;
  } vec_t;

  vec_t vecs [N + 1];

  // Reference model state for the randomized phase.
  bit          m_set [N];
  logic [15:0] m_mem [N];
  int          m_outs;
  bit          p_valid;
  int          p_tag;
  bit          p_last;
  bit          m_err;

  initial begin
    drive(1'b0, 16'h0, 1'b0, 5'd0, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state.
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_cpl_ready", cpl_ready, 1);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_rec_valid", rec_valid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_unalloc, 0);

    // Table: 32 back-to-back allocs, then one attempt while full.
    for (int i = 0; i < N; i++) begin
      vecs[i].av        = 1'b1;
      vecs[i].rec       = 16'(16'h100 + i);
      vecs[i].exp_ready = 1'b1;
      vecs[i].exp_tag   = 5'(i);
      vecs[i].exp_out   = 6'(i);
    end
    vecs[N].av        = 1'b1;
    vecs[N].rec       = 16'hdead;
    vecs[N].exp_ready = 1'b0;
    vecs[N].exp_tag   = 5'd0;
    vecs[N].exp_out   = 6'd32;
    for (int i = 0; i <= N; i++) begin
      drive(vecs[i].av, vecs[i].rec, 1'b0, 5'd0, 1'b0, 1'b1);
      #1;
      chk("vec_alloc_ready", alloc_ready, vecs[i].exp_ready);
      chk("vec_outstanding", outstanding, vecs[i].exp_out);
      chk("vec_wr_en", ram_wr_en, vecs[i].exp_ready);
      if (vecs[i].exp_ready) begin
        chk("vec_alloc_tag", alloc_tag, vecs[i].exp_tag);
        chk("vec_wr_addr", ram_wr_addr, vecs[i].exp_tag);
        chk("vec_wr_data", ram_wr_data, vecs[i].rec);
      end
      tick();
    end
    drive(1'b0, 16'h0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    chk("full_after_32", full, 1);
    chk("empty_after_32", empty, 0);
    for (int i = 0; i < N; i++) chk("ram_contents", mem[i], 32'h100 + i);

    // Lookup tag 5 as last, consume, then reallocate it.
    drive(1'b0, 16'h0, 1'b1, 5'd5, 1'b1, 1'b1);
    #1;
    chk("t5_cpl_ready", cpl_ready, 1);
    chk("t5_rd_addr", ram_rd_addr, 5);
    tick();
    drive(1'b0, 16'h0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    chk("t5_rec_valid", rec_valid, 1);
    chk("t5_rec_data", rec_data, 16'h105);
    chk("t5_rec_tag", rec_tag, 5);
    chk("t5_rec_last", rec_last, 1);
    chk("t5_out_before", outstanding, 32);
    tick();
    chk("t5_out_after", outstanding, 31);
    chk("t5_free_tag", alloc_tag, 5);
    chk("t5_rec_gone", rec_valid, 0);
    drive(1'b1, 16'h105, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    chk("t5_regrant_wr", ram_wr_en, 1);
    chk("t5_regrant_addr", ram_wr_addr, 5);
    tick();
    drive(1'b0, 16'h0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    chk("t5_out_refill", outstanding, 32);
    chk("t5_full_refill", full, 1);

    // Stall on tag 7, then tag 8 accepted the cycle rec_ready rises.
    drive(1'b0, 16'h0, 1'b1, 5'd7, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 1'b1, 5'd8, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t7_rec_valid", rec_valid, 1);
      chk("t7_rec_data", rec_data, 16'h107);
      chk("t7_cpl_ready", cpl_ready, 0);
      chk("t7_rd_addr_held", ram_rd_addr, 7);
      tick();
    end
    rec_ready = 1'b1;
    #1;
    chk("t8_cpl_ready", cpl_ready, 1);
    chk("t8_rd_addr", ram_rd_addr, 8);
    tick();
    drive(1'b0, 16'h0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    chk("t8_rec_valid", rec_valid, 1);
    chk("t8_rec_data", rec_data, 16'h108);
    chk("t8_rec_tag", rec_tag, 8);
    tick();
    chk("t8_out", outstanding, 32);

    // Three completions on tag 9; only the last one frees it.
    drive(1'b0, 16'h0, 1'b1, 5'd9, 1'b0, 1'b1);
    tick();
    #1;
    chk("t9_a_data", rec_data, 16'h109);
    chk("t9_a_last", rec_last, 0);
    tick();
    drive(1'b0, 16'h0, 1'b1, 5'd9, 1'b1, 1'b1);
    #1;
    chk("t9_b_data", rec_data, 16'h109);
    chk("t9_b_out", outstanding, 32);
    tick();
    drive(1'b0, 16'h0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    chk("t9_c_data", rec_data, 16'h109);
    chk("t9_c_last", rec_last, 1);
    chk("t9_c_out", outstanding, 32);
    tick();
    chk("t9_freed_out", outstanding, 31);
    chk("t9_freed_tag", alloc_tag, 9);
    drive(1'b1, 16'h109, 1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 16'h0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    chk("t9_refull", full, 1);

    // Release of tag 2 while full and alloc requested: no grant until next cycle.
    drive(1'b0, 16'h0, 1'b1, 5'd2, 1'b1, 1'b1);
    tick();
    drive(1'b1, 16'h102, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    chk("t2_blocked_ready", alloc_ready, 0);
    chk("t2_blocked_wr", ram_wr_en, 0);
    tick();
    chk("t2_grant_ready", alloc_ready, 1);
    chk("t2_grant_tag", alloc_tag, 2);
    chk("t2_grant_wr", ram_wr_en, 1);
    tick();
    drive(1'b0, 16'h0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    chk("t2_out", outstanding, 32);

    // Not full: alloc and release together keep the count and skip the freed tag.
    drive(1'b0, 16'h0, 1'b1, 5'd4, 1'b1, 1'b1);
    tick();
    drive(1'b0, 16'h0, 1'b1, 5'd6, 1'b1, 1'b1);
    tick();
    chk("t46_out_31", outstanding, 31);
    drive(1'b1, 16'h104, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    chk("t46_grant_4", alloc_tag, 4);
    chk("t46_wr_en", ram_wr_en, 1);
    tick();
    drive(1'b0, 16'h0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    chk("t46_out_hold", outstanding, 31);
    chk("t46_next_6", alloc_tag, 6);

    // Reset mid-stream with a lookup in flight.
    drive(1'b1, 16'h106, 1'b1, 5'd11, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    chk("mrst_empty", empty, 1);
    chk("mrst_rec_valid", rec_valid, 0);
    chk("mrst_alloc_tag", alloc_tag, 0);
    chk("mrst_outstanding", outstanding, 0);

    // Lookup of an unallocated tag pulses the error for one cycle.
    drive(1'b0, 16'h0, 1'b1, 5'd3, 1'b1, 1'b1);
    #1;
    chk("u3_cpl_ready", cpl_ready, 1);
    tick();
    drive(1'b0, 16'h0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    chk("u3_err_pulse", err_unalloc, 1);
    chk("u3_rec_valid", rec_valid, 0);
    tick();
    chk("u3_err_gone", err_unalloc, 0);
    chk("u3_rec_valid2", rec_valid, 0);
    chk("u3_outstanding", outstanding, 0);

    // Randomized traffic against a set/queue-level model.
    for (int i = 0; i < N; i++) begin
      m_set[i] = 1'b0;
      m_mem[i] = '0;
    end
    m_outs  = 0;
    p_valid = 1'b0;
    p_tag   = 0;
    p_last  = 1'b0;
    m_err   = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        av, cv, cl, rr, exp_full, exp_cr, exp_wr, consume, rel, hit;
      logic [15:0] arec;
      logic [4:0]  ct;
      int          ff, rel_tag;
      av   = ($urandom_range(0, 9) < 5);
      arec = 16'($urandom);
      cv   = ($urandom_range(0, 9) < 6);
      ct   = 5'($urandom_range(0, N - 1));
      cl   = ($urandom_range(0, 2) == 0);
      rr   = ($urandom_range(0, 9) < 7);
      // Avoid re-reading a tag on the very cycle its last record frees it.
      if (cv && p_valid && p_last && int'(ct) == p_tag) cv = 1'b0;
      drive(av, arec, cv, ct, cl, rr);
      #1;
      exp_full = (m_outs == N);
      ff = -1;
      for (int t = N - 1; t >= 0; t--) if (!m_set[t]) ff = t;
      exp_cr = !p_valid || rr;
      exp_wr = av && !exp_full;
      chk("rnd_full", full, exp_full);
      chk("rnd_empty", empty, m_outs == 0);
      chk("rnd_outstanding", outstanding, m_outs);
      chk("rnd_alloc_ready", alloc_ready, !exp_full);
      if (!exp_full) chk("rnd_alloc_tag", alloc_tag, ff);
      chk("rnd_wr_en", ram_wr_en, exp_wr);
      if (exp_wr) chk("rnd_wr_data", ram_wr_data, arec);
      chk("rnd_cpl_ready", cpl_ready, exp_cr);
      if (cv && exp_cr) chk("rnd_rd_addr", ram_rd_addr, ct);
      chk("rnd_rec_valid", rec_valid, p_valid);
      chk("rnd_err", err_unalloc, m_err);
      if (p_valid) begin
        chk("rnd_rec_tag", rec_tag, p_tag);
        chk("rnd_rec_last", rec_last, p_last);
        chk("rnd_rec_data", rec_data, m_mem[p_tag]);
      end
      consume = p_valid && rr;
      rel     = consume && p_last;
      rel_tag = p_tag;
      if (cv && exp_cr) begin
        hit     = m_set[ct];
        m_err   = !hit;
        p_valid = hit;
        if (hit) begin
          p_tag  = int'(ct);
          p_last = cl;
        end
      end else begin
        m_err = 1'b0;
        if (consume) p_valid = 1'b0;
      end
      if (rel) begin
        m_set[rel_tag] = 1'b0;
        m_outs--;
      end
      if (exp_wr) begin
        m_set[ff] = 1'b1;
        m_mem[ff] = arec;
        m_outs++;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/request_recorder_ctrl.md
Name: request_recorder_ctrl

Overview:
- Tag allocator and sequencer for the slave bridge's request-recorder dual-port RAM.
- Outbound non-posted requests get a free tag; their record (AXI ID, length, attributes) is written at that tag's RAM address.
- Returning completions look up their record by tag.
- A tag is released only after the final completion's record has been consumed downstream, so the RAM entry is never overwritten while in use.

Parameters:
- TAG_NUM, 32, number of tags = RAM depth.
- TAG_W, $clog2(TAG_NUM), tag/address width (derived).
- REC_W, 16, record width = RAM data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_valid  in  1  requester wants a tag
- alloc_record  in  REC_W  record to store
- alloc_ready  out  1  tag available
- alloc_tag  out  TAG_W  tag granted on handshake
- cpl_valid  in  1  completion lookup request
- cpl_tag  in  TAG_W  completion tag
- cpl_last  in  1  final completion for this tag
- cpl_ready  out  1  lookup accepted
- rec_valid  out  1  record output valid
- rec_ready  in  1  downstream consumes record
- rec_tag  out  TAG_W  tag of presented record
- rec_data  out  REC_W  record data
- rec_last  out  1  copy of cpl_last
- ram_wr_en  out  1  RAM write enable
- ram_wr_addr  out  TAG_W  RAM write address
- ram_wr_data  out  REC_W  RAM write data
- ram_rd_addr  out  TAG_W  RAM read address (RAM read is synchronous, 1 cycle)
- ram_rd_data  in  REC_W  RAM read data
- outstanding  out  TAG_W+1  allocated tag count
- full  out  1  all tags allocated
- empty  out  1  no tags allocated
- err_unalloc  out  1  one-cycle pulse: completion hit an unallocated tag

Behaviour:
- Reset (rst sampled high on clk edge):
  - Clears the alloc bitmap, outstanding, rec_valid, rec_tag, rec_last, err_unalloc and the held read address.
  - Outputs after reset: alloc_ready=1, alloc_tag=0, cpl_ready=1, full=0, empty=1, ram_wr_en=0.
  - RAM contents are not cleared; rec_data is don't-care while rec_valid=0.
  - Reset mid-operation abandons all tags and any pending record immediately.
- Allocation:
  - alloc_tag = lowest-index clear bitmap bit (combinational); alloc_ready = !full.
  - Handshake (alloc_valid && alloc_ready): ram_wr_en=1, ram_wr_addr=alloc_tag, ram_wr_data=alloc_record, all combinational in the same cycle.
  - The bitmap bit is set at the next edge.
- Lookup:
  - cpl_ready = !rec_valid || rec_ready (single output stage, full throughput).
  - ram_rd_addr = cpl_tag on a cpl handshake in that cycle; otherwise the held address register. The register updates on each handshake, keeping RAM output stable while stalled.
  - Handshake in cycle N with the tag allocated: rec_valid=1 in cycle N+1; rec_tag and rec_last registered; rec_data = ram_rd_data.
  - rec_valid stays high until rec_ready; new lookups are accepted in the same cycle the record is consumed.
- Unallocated tag: the cpl handshake completes, rec_valid does not assert, err_unalloc=1 in cycle N+1 only, bitmap unchanged.
- Release:
  - When rec_valid && rec_ready && rec_last, the rec_tag bitmap bit clears at the next edge.
  - Non-last completions do not release the tag.
- Same-cycle alloc and release: alloc selects from the pre-release bitmap, so the freed tag cannot be regranted that cycle; outstanding is unchanged (+1 -1).
- outstanding = popcount equivalent (up/down counter); full = (outstanding==TAG_NUM); empty = (outstanding==0).
- No RAM read/write collision: writes only target free tags; reads of free tags are flagged and discarded.

Decomposition:
- axi_slave_package gains:
  - REQ_TAG_NUM, REQ_TAG_W, REQ_REC_W constants.
  - req_record_t packed struct {axi_id, axi_len, axi_size, burst} sized to REQ_REC_W.
- Sub-module tag_free_finder: parameterised lowest-clear-bit priority encoder (bitmap in; tag, any_free out).

Test Plan:
- Reset, then 32 back-to-back allocs with records 'h100+i -> tags 0..31 in order; full=1 after the 32nd; alloc_ready=0; RAM holds 'h100+i at address i.
- cpl_tag=5, cpl_last=1, rec_ready=1 -> rec_valid next cycle, rec_data='h105, rec_tag=5; bit 5 freed; next alloc gets tag 5; outstanding 31 -> 32.
- cpl_tag=7 with rec_ready=0 for 3 cycles -> rec_valid and rec_data='h107 held stable, cpl_ready=0; a second cpl on tag 8 is accepted the cycle rec_ready rises, and 'h108 appears the next cycle.
- cpl_tag=9, cpl_last=0 twice, then cpl_last=1 -> three records 'h109; tag 9 freed only after the third is consumed.
- After reset, cpl_tag=3 -> err_unalloc pulses exactly one cycle; rec_valid stays 0; outstanding stays 0.
- With tags 0..31 allocated: release of tag 2 and alloc_valid in the same cycle -> no grant that cycle (full); the following cycle grants tag 2; outstanding holds at 32. Assert rst mid-stream -> next cycle empty=1, rec_valid=0, alloc_tag=0.
